usr_result_fifo: RTL

- Downstream capture stage for the universal shift register.
- Accepts the register's parallel output (regOut) and its valid flag (outValid), and buffers each valid word in a small first-word-fall-through FIFO.
- Presents the buffered words on a valid/ready stream for a later consumer (Wishbone readback or IO serializer).
- Detects and flags dropped words when the consumer stalls.

---
 rtl/usr_pkg.sv | 13 +
 rtl/usr_fifo_mem.sv | 25 ++
 rtl/usr_result_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register and its result FIFO.
package usr_pkg;

  localparam int unsigned USR_BITS       = 8;
  localparam int unsigned USR_FIFO_DEPTH = 8;

  // Shift register ctrl field encodings
  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] SER  = 2'b11;

endpackage

// File: rtl/usr_fifo_mem.sv
// Storage array for usr_result_fifo: one write port, one asynchronous read port, no reset.
module usr_fifo_mem #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [BITS-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [BITS-1:0] rdata_o
);

  logic [BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usr_result_fifo.sv
// First-word-fall-through capture FIFO behind the shift register, with sticky drop flag.
// Define USR_FIFO_CHANGE_FILTER_EN to suppress captures that repeat the last pushed word.
module usr_result_fifo
  import usr_pkg::*;
#(
  parameter int unsigned BITS  = USR_BITS,
  parameter int unsigned DEPTH = USR_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW:0]     level,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  input  logic            clear_ovf
);

  // Pointer MSB is the wrap bit separating full from empty
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, drop, capture, suppress;
  logic [BITS-1:0] rdata;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign out_valid = !empty;
  assign out_data  = out_valid ? rdata : '0;
  assign overflow  = ovf_q;

  assign pop     = out_valid && out_ready;
  assign capture = in_valid && !suppress;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

`ifdef USR_FIFO_CHANGE_FILTER_EN
  logic [BITS-1:0] last_q, last_d;
  logic            last_vld_q, last_vld_d;

  assign suppress = last_vld_q && (in_data == last_q);

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (push) begin
      last_d     = in_data;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    // A drop in the same cycle as clear_ovf keeps the flag set
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  usr_fifo_mem #(
    .BITS  (BITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

endmodule
